// File: rtl/mac_lane_acc_if.sv
// Stream bundle for mac_lane_acc: input beat channel (pixel/kernel lanes) and
// scaled window result channel. Both channels use valid/ready handshakes.
interface mac_lane_acc_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int OUT_W  = 32
);
    // A transfer happens on a rising edge where valid & ready are both high;
    // valid never waits for ready, and data is stable while valid & ~ready.
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   pixel_in;
    logic [LANES*DATA_W-1:0]   kernel_in;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   mac_out;
    logic                      sat_flag;

    modport master (
        output in_valid, pixel_in, kernel_in, out_ready,
        input  in_ready, out_valid, mac_out, sat_flag
    );

    modport slave (
        input  in_valid, pixel_in, kernel_in, out_ready,
        output in_ready, out_valid, mac_out, sat_flag
    );
endinterface

// File: rtl/mac_lane_acc.sv
// Multi-lane pipelined signed MAC: per-lane products, lane sum, window
// accumulation over cfg_klen beats, then arithmetic shift and signed clamp.
module mac_lane_acc #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int KLEN_W = 8,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KLEN_W-1:0] cfg_klen,
    mac_lane_acc_if.slave     bus,
    output logic              busy
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic                     stall;
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     v1_q;
    logic signed [SUM_W-1:0]  sum_d, sum_q;
    logic                     v2_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic [KLEN_W-1:0]        cnt_d, cnt_q;
    logic [KLEN_W-1:0]        klen_d, klen_q;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [OUT_W-1:0]  out_d, out_q;
    logic                     sat_d, sat_q;
    logic                     out_valid_q;
    logic                     beat, last, load;

    // The whole pipe freezes while a finished result waits for the consumer.
    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = $signed(bus.pixel_in[i*DATA_W +: DATA_W]) *
                        $signed(bus.kernel_in[i*DATA_W +: DATA_W]);
        end
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    always_comb begin
        beat   = v2_q & ~stall;
        klen_d = klen_q;
        if (cnt_q == '0) begin
            klen_d = (cfg_klen == '0) ? KLEN_W'(1) : cfg_klen;
            acc_d  = ACC_W'(sum_q);
        end else begin
            acc_d  = acc_q + ACC_W'(sum_q);
        end
        last  = (cnt_q == klen_d - KLEN_W'(1));
        load  = beat & last;
        cnt_d = last ? '0 : cnt_q + KLEN_W'(1);

        shifted = acc_d >>> SHIFT;
        sat_d   = 1'b1;
        if (shifted > OUT_MAX) begin
            out_d = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            out_d = OUT_MIN[OUT_W-1:0];
        end else begin
            out_d = shifted[OUT_W-1:0];
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
            sum_q <= '0;
        end else if (!stall) begin
            v1_q <= bus.in_valid;
            for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
            v2_q  <= v1_q;
            sum_q <= sum_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            klen_q <= '0;
        end else if (beat) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            klen_q <= klen_d;
        end
    end

    // A new result may land in the same cycle the previous one drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            sat_q       <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_q       <= out_d;
            sat_q       <= sat_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.mac_out   = out_q;
    assign bus.sat_flag  = sat_q;
    assign busy          = v1_q | v2_q | (cnt_q != '0);
endmodule

// File: tb/tb_mac_lane_acc.sv
// Directed-vector bench for mac_lane_acc with an expected-result queue and an
// independent output monitor; a second instance covers SHIFT=2.
module tb_mac_lane_acc;
    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int OUT_W  = 32;
    localparam int KLEN_W = 8;

    logic              clk;
    logic              rst;
    logic [KLEN_W-1:0] klen;
    logic [KLEN_W-1:0] klen2;
    logic              busy, busy2;
    int                checks, errors, cyc;

    logic [OUT_W:0] exp_q[$];
    logic [OUT_W:0] exp2_q[$];
    int             hs_cyc[$];

    mac_lane_acc_if #(.DATA_W(DATA_W), .LANES(LANES), .OUT_W(OUT_W)) bus ();
    mac_lane_acc_if #(.DATA_W(DATA_W), .LANES(LANES), .OUT_W(OUT_W)) bus2 ();

    mac_lane_acc #(.DATA_W(DATA_W), .LANES(LANES), .KLEN_W(KLEN_W),
                   .ACC_W(40), .OUT_W(OUT_W), .SHIFT(0)) u_dut (
        .clk(clk), .rst(rst), .cfg_klen(klen), .bus(bus), .busy(busy));

    mac_lane_acc #(.DATA_W(DATA_W), .LANES(LANES), .KLEN_W(KLEN_W),
                   .ACC_W(40), .OUT_W(OUT_W), .SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .cfg_klen(klen2), .bus(bus2), .busy(busy2));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LANES*DATA_W-1:0] pk(input int a, input int b,
                                                   input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic sat, input int val);
        exp_q.push_back({sat, 32'(val)});
    endtask

    // driver tasks
    task automatic drive_beat(input logic [LANES*DATA_W-1:0] p, input logic [LANES*DATA_W-1:0] k);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.pixel_in  = p;
        bus.kernel_in = k;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected acceptance", n);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.pixel_in  = '0;
        bus.kernel_in = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0 || busy || busy2 ||
                bus.out_valid || bus2.out_valid) && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [OUT_W:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                checks++;
                if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                    errors++;
                    $display("FAIL in_ready: got %0b with out_valid=%0b out_ready=%0b",
                             bus.in_ready, bus.out_valid, bus.out_ready);
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got %0h, expected no result",
                                 {bus.sat_flag, bus.mac_out});
                    end else begin
                        e = exp_q.pop_front();
                        hs_cyc.push_back(cyc);
                        if ({bus.sat_flag, bus.mac_out} !== e) begin
                            errors++;
                            $display("FAIL result: got sat=%0b mac=%0h expected sat=%0b mac=%0h",
                                     bus.sat_flag, bus.mac_out, e[OUT_W], e[OUT_W-1:0]);
                        end
                    end
                end
                if (bus2.out_valid && bus2.out_ready) begin
                    checks++;
                    if (exp2_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_shift_result: got %0h, expected no result",
                                 {bus2.sat_flag, bus2.mac_out});
                    end else begin
                        e = exp2_q.pop_front();
                        if ({bus2.sat_flag, bus2.mac_out} !== e) begin
                            errors++;
                            $display("FAIL shift_result: got sat=%0b mac=%0h expected sat=%0b mac=%0h",
                                     bus2.sat_flag, bus2.mac_out, e[OUT_W], e[OUT_W-1:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        klen   = 8'd1;
        klen2  = 8'd1;
        bus.in_valid   = 1'b0;
        bus.pixel_in   = '0;
        bus.kernel_in  = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.pixel_in  = '0;
        bus2.kernel_in = '0;
        bus2.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mac_out", 64'(bus.mac_out), 64'd0);
        chk("rst_sat_flag", 64'(bus.sat_flag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        // 1: klen=3, every lane 1*2 -> 3 * 8 = 24, plus output latency
        klen = 8'd3;
        push(1'b0, 24);
        repeat (3) drive_beat(pk(1, 1, 1, 1), pk(2, 2, 2, 2));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 chk("lat_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        #2 chk("lat_cycle2", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        #2 chk("lat_cycle3", 64'(bus.out_valid), 64'd1);
        wait_drain();

        // 2: klen=1, four beats of -3*5 -> -15 on consecutive cycles
        klen = 8'd1;
        hs_cyc.delete();
        repeat (4) push(1'b0, -15);
        repeat (4) drive_beat(pk(-3, 0, 0, 0), pk(5, 0, 0, 0));
        idle();
        wait_drain();
        chk("b2b_count", 64'(hs_cyc.size()), 64'd4);
        if (hs_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("b2b_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
        end

        // 3: saturation at both ends
        push(1'b1, 32'h7FFFFFFF);
        push(1'b1, 32'h80000000);
        drive_beat(pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767));
        drive_beat(pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767));
        idle();
        wait_drain();

        // 4: klen=2, values 1..10 with a 5-cycle consumer stall mid-stream
        klen = 8'd2;
        push(1'b0, 3);
        push(1'b0, 7);
        push(1'b0, 11);
        push(1'b0, 15);
        push(1'b0, 19);
        fork
            begin
                for (int v = 1; v <= 10; v++) drive_beat(pk(v, 0, 0, 0), pk(1, 0, 0, 0));
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // 5: reset mid-window discards the partial sum
        klen = 8'd4;
        repeat (2) drive_beat(pk(7, 7, 7, 7), pk(3, 3, 3, 3));
        idle();
        repeat (3) @(negedge clk);
        chk("busy_partial", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        rst = 1'b0;
        push(1'b0, 100);
        repeat (4) drive_beat(pk(5, 0, 0, 0), pk(5, 0, 0, 0));
        idle();
        wait_drain();

        // 6a: klen=0 behaves as 1
        klen = 8'd0;
        push(1'b0, 2);
        push(1'b0, 3);
        push(1'b0, 4);
        drive_beat(pk(2, 0, 0, 0), pk(1, 0, 0, 0));
        drive_beat(pk(3, 0, 0, 0), pk(1, 0, 0, 0));
        drive_beat(pk(4, 0, 0, 0), pk(1, 0, 0, 0));
        idle();
        wait_drain();

        // 6b: klen changes 4->2 once the window has started
        klen = 8'd4;
        push(1'b0, 10);
        push(1'b0, 11);
        drive_beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0));
        idle();
        repeat (3) @(negedge clk);
        klen = 8'd2;
        for (int v = 2; v <= 6; v++) drive_beat(pk(v, 0, 0, 0), pk(1, 0, 0, 0));
        idle();
        wait_drain();

        // 6c: SHIFT=2 instance, -5 >>> 2 floors to -2
        exp2_q.push_back({1'b0, 32'hFFFFFFFE});
        @(negedge clk);
        bus2.in_valid  = 1'b1;
        bus2.pixel_in  = pk(-5, 0, 0, 0);
        bus2.kernel_in = pk(1, 0, 0, 0);
        @(negedge clk);
        bus2.in_valid  = 1'b0;
        bus2.pixel_in  = '0;
        bus2.kernel_in = '0;
        wait_drain();

        chk("final_queue_empty", 64'(exp_q.size() + exp2_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
